// File: rtl/apb_split_timeout.sv
// APB one-to-NSLV address splitter with decode-miss SLVERR and saturating error counter.
// Define APB_SPLIT_TIMEOUT_EN to build the access-phase timeout abort (ABORT state, tcnt, timeout_pulse).
module apb_split_timeout #(
  parameter int          NSLV    = 4,
  parameter int          SELLO   = 12,
  parameter int          SELW    = 2,
  parameter logic [7:0]  SLVMASK = 8'h0F,
  parameter int          TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_psel,
  input  logic                 s_penable,
  input  logic                 s_pwrite,
  input  logic [31:0]          s_paddr,
  input  logic [31:0]          s_pwdata,
  input  logic [3:0]           s_pstrb,
  output logic                 s_pready,
  output logic [1:0]           s_presp,
  output logic [31:0]          s_prdata,
  output logic [NSLV-1:0]      m_psel,
  output logic                 m_penable,
  output logic                 m_pwrite,
  output logic [31:0]          m_paddr,
  output logic [31:0]          m_pwdata,
  output logic [3:0]           m_pstrb,
  input  logic [NSLV-1:0]      m_pready,
  input  logic [2*NSLV-1:0]    m_presp,
  input  logic [32*NSLV-1:0]   m_prdata,
  output logic [15:0]          err_count,
  output logic                 timeout_pulse
);

  typedef enum logic [1:0] {IDLE, ACC, MISS, ABORT} state_t;

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  if (NSLV < 1 || NSLV > 8 || (1 << SELW) < NSLV || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_params
    $error("apb_split_timeout: illegal parameter combination");
  end

  state_t            state, state_d;
  logic [SELW-1:0]   idx, idx_q;
  logic              hit;
  logic [NSLV-1:0]   dec_oh, acc_oh;
  logic              sel_ready;
  logic [1:0]        sel_resp;
  logic [31:0]       sel_rdata;
  logic              setup, access, load_idx;

`ifdef APB_SPLIT_TIMEOUT_EN
  localparam logic [15:0] TLIM = 16'(TIMEOUT - 1);
  logic [15:0] tcnt;
  logic        tcnt_inc;
`endif

  assign setup    = s_psel && !s_penable;
  assign access   = s_psel && s_penable;
  assign load_idx = (state == IDLE) && setup && hit;

  assign m_pwrite = s_pwrite;
  assign m_paddr  = s_paddr;
  assign m_pwdata = s_pwdata;
  assign m_pstrb  = s_pstrb;

  // Decode the incoming address and mux the slave return path selected by idx_q.
  always_comb begin
    idx       = s_paddr[SELLO+SELW-1:SELLO];
    hit       = 1'b0;
    dec_oh    = '0;
    acc_oh    = '0;
    sel_ready = 1'b0;
    sel_resp  = 2'b00;
    sel_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (idx == SELW'(i) && SLVMASK[i]) begin
        hit       = 1'b1;
        dec_oh[i] = 1'b1;
      end
      if (idx_q == SELW'(i)) begin
        acc_oh[i] = 1'b1;
        sel_ready = m_pready[i];
        sel_resp  = m_presp[2*i +: 2];
        sel_rdata = m_prdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d       = state;
    m_psel        = '0;
    m_penable     = 1'b0;
    s_pready      = 1'b0;
    s_presp       = 2'b00;
    s_prdata      = '0;
    timeout_pulse = 1'b0;
`ifdef APB_SPLIT_TIMEOUT_EN
    tcnt_inc      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (setup) begin
          s_pready = 1'b1;
          if (hit) begin
            m_psel  = dec_oh;
            state_d = ACC;
          end else begin
            state_d = MISS;
          end
        end
      end
      ACC: begin
        if (!s_psel) begin
          state_d = IDLE;
        end else begin
          m_psel    = acc_oh;
          m_penable = s_penable;
          s_pready  = sel_ready;
          s_presp   = sel_resp;
          s_prdata  = sel_rdata;
          if (access) begin
            if (sel_ready) begin
              state_d = IDLE;
            end
`ifdef APB_SPLIT_TIMEOUT_EN
            else if (tcnt == TLIM) begin
              state_d = ABORT;
            end else begin
              tcnt_inc = 1'b1;
            end
`endif
          end
        end
      end
      MISS: begin
        if (!s_psel) begin
          state_d = IDLE;
        end else if (access) begin
          s_pready = 1'b1;
          s_presp  = RESP_SLVERR;
          state_d  = IDLE;
        end
      end
`ifdef APB_SPLIT_TIMEOUT_EN
      ABORT: begin
        s_pready      = 1'b1;
        s_presp       = RESP_SLVERR;
        timeout_pulse = 1'b1;
        state_d       = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx_q <= '0;
    end else begin
      state <= state_d;
      if (load_idx) idx_q <= idx;
    end
  end

`ifdef APB_SPLIT_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if (load_idx) begin
      tcnt <= '0;
    end else if (tcnt_inc) begin
      tcnt <= tcnt + 16'd1;
    end
  end
`endif

  // Every SLVERR handed upstream on an access cycle is counted, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (s_pready && s_presp == RESP_SLVERR && access && err_count != 16'hFFFF) begin
      err_count <= err_count + 16'd1;
    end
  end

endmodule
